// File: rtl/fm_psg_audio_mixer.sv
// ============================================================================
// Module  : fm_psg_audio_mixer
// Brief   : Assembles a 6-channel stereo FM frame from the time-multiplexed
//           DAC stream, mixes in the PSG, saturates and emits one sample/frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_psg_audio_mixer #(
  parameter int FM_SHIFT  = 4,
  parameter int PSG_SHIFT = 2,
  parameter int SAT_EN    = 1
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic        MCLK_e,
  input  logic        fm_clk1,
  input  logic [2:0]  DAC_ch_index,
  input  logic [8:0]  MOL,
  input  logic [8:0]  MOR,
  input  logic [15:0] PSG,
  input  logic        MUTE,
  input  logic        err_clr,
  output logic [15:0] AUD_L,
  output logic [15:0] AUD_R,
  output logic        AUD_valid,
  output logic        FRAME_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SUM   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               fm_clk1_q;
  logic [5:0]         mask_q, mask_d;
  logic signed [11:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [17:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic [15:0]        aud_l_q, aud_l_d, aud_r_q, aud_r_d;
  logic               aud_valid_q, aud_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               cap;
  logic               err_set;
  logic signed [11:0] smp_l, smp_r;
  logic signed [15:0] psg_c;
  logic signed [17:0] psg_ext, fm_l_ext, fm_r_ext;

  // Slots 6 and 7 are not FM channels and never touch the frame state.
  assign cap   = fm_clk1 & ~fm_clk1_q & MCLK_e & (DAC_ch_index <= 3'd5);
  assign smp_l = {{3{MOL[8]}}, MOL};
  assign smp_r = {{3{MOR[8]}}, MOR};
  assign psg_c = {~PSG[15], PSG[14:0]};

  always_comb begin
    psg_ext  = {{2{psg_c[15]}}, psg_c};
    psg_ext  = psg_ext >>> PSG_SHIFT;
    fm_l_ext = {{6{acc_l_q[11]}}, acc_l_q};
    fm_l_ext = fm_l_ext <<< FM_SHIFT;
    fm_r_ext = {{6{acc_r_q[11]}}, acc_r_q};
    fm_r_ext = fm_r_ext <<< FM_SHIFT;
  end

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    logic [15:0] r;
    r = v[15:0];
    if (SAT_EN != 0) begin
      if (v > 18'sd32767)
        r = 16'h7FFF;
      else if (v < -18'sd32768)
        r = 16'h8000;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;
    aud_l_d     = aud_l_q;
    aud_r_d     = aud_r_q;
    aud_valid_d = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cap && DAC_ch_index == 3'd0) begin
          acc_l_d = smp_l;
          acc_r_d = smp_r;
          mask_d  = 6'b000001;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (cap) begin
          if (DAC_ch_index == 3'd0) begin
            err_set = 1'b1;
            acc_l_d = smp_l;
            acc_r_d = smp_r;
            mask_d  = 6'b000001;
          end else begin
            acc_l_d = acc_l_q + smp_l;
            acc_r_d = acc_r_q + smp_r;
            if (mask_q[DAC_ch_index])
              err_set = 1'b1;
            mask_d[DAC_ch_index] = 1'b1;
            if (DAC_ch_index == 3'd5) begin
              state_d = S_SUM;
              if (mask_d != 6'h3F)
                err_set = 1'b1;
            end
          end
        end
      end
      S_SUM: begin
        mix_l_d = fm_l_ext + psg_ext;
        mix_r_d = fm_r_ext + psg_ext;
        err_set = cap;
        state_d = S_OUT;
      end
      default: begin
        aud_l_d     = MUTE ? 16'h0000 : sat16(mix_l_q);
        aud_r_d     = MUTE ? 16'h0000 : sat16(mix_r_q);
        aud_valid_d = 1'b1;
        err_set     = cap;
        state_d     = S_IDLE;
      end
    endcase
    // A set wins over a simultaneous clear.
    frame_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state_q     <= S_IDLE;
      fm_clk1_q   <= 1'b1;
      mask_q      <= 6'd0;
      acc_l_q     <= 12'sd0;
      acc_r_q     <= 12'sd0;
      mix_l_q     <= 18'sd0;
      mix_r_q     <= 18'sd0;
      aud_l_q     <= 16'h0000;
      aud_r_q     <= 16'h0000;
      aud_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (MCLK_e) begin
      state_q     <= state_d;
      fm_clk1_q   <= fm_clk1;
      mask_q      <= mask_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
      aud_l_q     <= aud_l_d;
      aud_r_q     <= aud_r_d;
      aud_valid_q <= aud_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign AUD_L     = aud_l_q;
  assign AUD_R     = aud_r_q;
  assign AUD_valid = aud_valid_q;
  assign FRAME_ERR = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fm_psg_audio_mixer.sv
// ============================================================================
// Module  : tb_fm_psg_audio_mixer
// Brief   : Directed, table-driven bench for fm_psg_audio_mixer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fm_psg_audio_mixer;

  logic        MCLK = 1'b0;
  logic        SRES = 1'b0;
  logic        MCLK_e = 1'b1;
  logic        fm_clk1 = 1'b0;
  logic [2:0]  DAC_ch_index = 3'd0;
  logic [8:0]  MOL = 9'd0;
  logic [8:0]  MOR = 9'd0;
  logic [15:0] PSG = 16'h8000;
  logic        MUTE = 1'b0;
  logic        err_clr = 1'b0;

  logic [15:0] aud_l, aud_r, aud5_l, aud5_r, audw_l, audw_r;
  logic        aud_valid, frame_err, v5, e5, vw, ew;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic v_prev = 1'b0;

  always #5 MCLK = ~MCLK;

  fm_psg_audio_mixer u_dut (
    .MCLK(MCLK), .SRES(SRES), .MCLK_e(MCLK_e), .fm_clk1(fm_clk1),
    .DAC_ch_index(DAC_ch_index), .MOL(MOL), .MOR(MOR), .PSG(PSG),
    .MUTE(MUTE), .err_clr(err_clr), .AUD_L(aud_l), .AUD_R(aud_r),
    .AUD_valid(aud_valid), .FRAME_ERR(frame_err)
  );

  fm_psg_audio_mixer #(.FM_SHIFT(5)) u_dut5 (
    .MCLK(MCLK), .SRES(SRES), .MCLK_e(MCLK_e), .fm_clk1(fm_clk1),
    .DAC_ch_index(DAC_ch_index), .MOL(MOL), .MOR(MOR), .PSG(PSG),
    .MUTE(MUTE), .err_clr(err_clr), .AUD_L(aud5_l), .AUD_R(aud5_r),
    .AUD_valid(v5), .FRAME_ERR(e5)
  );

  fm_psg_audio_mixer #(.FM_SHIFT(5), .SAT_EN(0)) u_dutw (
    .MCLK(MCLK), .SRES(SRES), .MCLK_e(MCLK_e), .fm_clk1(fm_clk1),
    .DAC_ch_index(DAC_ch_index), .MOL(MOL), .MOR(MOR), .PSG(PSG),
    .MUTE(MUTE), .err_clr(err_clr), .AUD_L(audw_l), .AUD_R(audw_r),
    .AUD_valid(vw), .FRAME_ERR(ew)
  );

  // Counts rising edges of AUD_valid so a stretched strobe counts once.
  always @(negedge MCLK) begin
    if (aud_valid && !v_prev)
      vcount <= vcount + 1;
    v_prev <= aud_valid;
  end

  typedef struct {
    logic [8:0]  mol;
    logic [8:0]  mor;
    logic [15:0] psg;
    logic        mute;
    logic [15:0] el, er, e5l, e5r, ewl, ewr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic cap(input logic [2:0] ch, input logic [8:0] l, input logic [8:0] r);
    DAC_ch_index = ch;
    MOL = l;
    MOR = r;
    fm_clk1 = 1'b1;
    step();
    fm_clk1 = 1'b0;
    step();
  endtask

  task automatic run_frame(input logic [8:0] l, input logic [8:0] r);
    for (int c = 0; c < 6; c++)
      cap(3'(c), l, r);
  endtask

  initial begin
    int vs;
    logic [15:0] prev_l, prev_r;

    vecs[0] = '{9'd10,   9'd10,   16'h8000, 1'b0, 16'h03C0, 16'h03C0, 16'h0780, 16'h0780, 16'h0780, 16'h0780};
    vecs[1] = '{9'h0FF,  9'h0FF,  16'hFFFF, 1'b0, 16'h7F9F, 16'h7F9F, 16'h7FFF, 16'h7FFF, 16'hDF3F, 16'hDF3F};
    vecs[2] = '{9'h000,  9'h100,  16'h0000, 1'b0, 16'hE000, 16'h8000, 16'hE000, 16'h8000, 16'hE000, 16'h2000};
    vecs[3] = '{9'h1FF,  9'h001,  16'h8004, 1'b0, 16'hFFA1, 16'h0061, 16'hFF41, 16'h00C1, 16'hFF41, 16'h00C1};
    vecs[4] = '{9'h0FF,  9'h100,  16'h1234, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    // Reset state
    step();
    step();
    chk("reset_aud_l", aud_l, 16'h0);
    chk("reset_aud_r", aud_r, 16'h0);
    chk("reset_valid", 16'(aud_valid), 16'h0);
    chk("reset_err", 16'(frame_err), 16'h0);
    SRES = 1'b1;
    step();

    // Table-driven whole frames
    for (int i = 0; i < 5; i++) begin
      PSG  = vecs[i].psg;
      MUTE = vecs[i].mute;
      run_frame(vecs[i].mol, vecs[i].mor);
      chk($sformatf("v%0d_latency_valid", i), 16'(aud_valid), 16'h0);
      step();
      chk($sformatf("v%0d_valid", i), 16'(aud_valid), 16'h1);
      chk($sformatf("v%0d_l", i), aud_l, vecs[i].el);
      chk($sformatf("v%0d_r", i), aud_r, vecs[i].er);
      chk($sformatf("v%0d_sat5_l", i), aud5_l, vecs[i].e5l);
      chk($sformatf("v%0d_sat5_r", i), aud5_r, vecs[i].e5r);
      chk($sformatf("v%0d_wrap5_l", i), audw_l, vecs[i].ewl);
      chk($sformatf("v%0d_wrap5_r", i), audw_r, vecs[i].ewr);
      chk($sformatf("v%0d_err", i), 16'(frame_err), 16'h0);
      step();
      chk($sformatf("v%0d_valid_drop", i), 16'(aud_valid), 16'h0);
    end
    MUTE = 1'b0;
    PSG  = 16'h8000;

    // Restart on ch0 mid-frame; ch6 capture ignored
    step();
    vs = vcount;
    cap(3'd0, 9'd100, 9'd100);
    cap(3'd1, 9'd100, 9'd100);
    cap(3'd2, 9'd100, 9'd100);
    chk("t4_err_before", 16'(frame_err), 16'h0);
    cap(3'd0, 9'd10, 9'd20);
    chk("t4_err_restart", 16'(frame_err), 16'h1);
    for (int c = 1; c < 6; c++) begin
      cap(3'(c), 9'd10, 9'd20);
      if (c == 2)
        cap(3'd6, 9'd100, 9'd100);
    end
    step();
    chk("t4_valid", 16'(aud_valid), 16'h1);
    chk("t4_l", aud_l, 16'h03C0);
    chk("t4_r", aud_r, 16'h0780);
    step();
    step();
    chk("t4_one_valid", 16'(vcount - vs), 16'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_cleared", 16'(frame_err), 16'h0);

    // Duplicate channel with simultaneous clear: set wins
    cap(3'd0, 9'd1, 9'd1);
    cap(3'd1, 9'd1, 9'd1);
    DAC_ch_index = 3'd1;
    fm_clk1 = 1'b1;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    fm_clk1 = 1'b0;
    step();
    chk("dup_set_beats_clr", 16'(frame_err), 16'h1);
    for (int c = 2; c < 6; c++)
      cap(3'(c), 9'd1, 9'd1);
    step();
    chk("dup_valid", 16'(aud_valid), 16'h1);
    chk("dup_l", aud_l, 16'h0070);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("dup_err_cleared", 16'(frame_err), 16'h0);

    // Incomplete frame ch0 then ch5
    cap(3'd0, 9'd2, 9'd2);
    cap(3'd5, 9'd2, 9'd2);
    chk("short_err", 16'(frame_err), 16'h1);
    step();
    chk("short_valid", 16'(aud_valid), 16'h1);
    chk("short_l", aud_l, 16'h0040);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("short_err_cleared", 16'(frame_err), 16'h0);

    // fm_clk1 edges only while disabled: nothing captured
    step();
    vs = vcount;
    prev_l = aud_l;
    prev_r = aud_r;
    for (int k = 0; k < 6; k++) begin
      MCLK_e = 1'b1;
      fm_clk1 = 1'b0;
      step();
      MCLK_e = 1'b0;
      DAC_ch_index = 3'd0;
      fm_clk1 = 1'b1;
      step();
      fm_clk1 = 1'b0;
      step();
    end
    MCLK_e = 1'b1;
    for (int c = 1; c < 6; c++)
      cap(3'(c), 9'd50, 9'd50);
    step();
    step();
    step();
    chk("t5_no_valid", 16'(vcount - vs), 16'h0);
    chk("t5_l_hold", aud_l, prev_l);
    chk("t5_r_hold", aud_r, prev_r);
    chk("t5_err", 16'(frame_err), 16'h0);

    // AUD_valid stretches while the enable is low
    run_frame(9'd5, 9'd5);
    step();
    chk("stretch_valid", 16'(aud_valid), 16'h1);
    MCLK_e = 1'b0;
    step();
    step();
    chk("stretch_hold", 16'(aud_valid), 16'h1);
    chk("stretch_l", aud_l, 16'h01E0);
    MCLK_e = 1'b1;
    step();
    chk("stretch_end", 16'(aud_valid), 16'h0);

    // Reset mid-frame, then a muted frame
    vs = vcount;
    cap(3'd0, 9'd7, 9'd7);
    cap(3'd1, 9'd7, 9'd7);
    cap(3'd2, 9'd7, 9'd7);
    cap(3'd3, 9'd7, 9'd7);
    SRES = 1'b0;
    #2;
    chk("t6_async_l", aud_l, 16'h0);
    chk("t6_async_r", aud_r, 16'h0);
    step();
    SRES = 1'b1;
    cap(3'd4, 9'd7, 9'd7);
    cap(3'd5, 9'd7, 9'd7);
    step();
    step();
    step();
    chk("t6_partial_discarded", 16'(vcount - vs), 16'h0);
    MUTE = 1'b1;
    run_frame(9'd50, 9'd50);
    step();
    chk("t6_valid", 16'(aud_valid), 16'h1);
    chk("t6_mute_l", aud_l, 16'h0);
    chk("t6_mute_r", aud_r, 16'h0);
    step();
    step();
    chk("t6_one_valid", 16'(vcount - vs), 16'h1);
    MUTE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
